// File: rtl/asi_pkg.sv
// Shared AXI slave interface constants, the read-beat sideband record and
// the byte-lane helpers used by the read memory stage.
package asi_pkg;

  localparam int AXI_AW         = 32;
  localparam int AXI_DW         = 64;
  localparam int AXI_SW         = 3;
  localparam int SLV_BYTEW      = AXI_DW / 8;
  localparam int SLV_BYTEW_LOG2 = $clog2(SLV_BYTEW);

  // Sideband that travels with a read beat while the SRAM is busy
  typedef struct packed {
    logic                 err;
    logic                 hit;
    logic [SLV_BYTEW-1:0] lanes;
    logic                 last;
  } rmem_beat_t;

  // Active byte lanes for a beat of 2^size bytes at byte offset off within
  // the word. The size container is aligned down, and lanes below the
  // address offset are dropped for unaligned beats. Oversize beats get a
  // full-word mask; they are errors and their data is zeroed anyway.
  function automatic logic [SLV_BYTEW-1:0] lane_mask(
    input logic [AXI_SW-1:0]         size,
    input logic [SLV_BYTEW_LOG2-1:0] off
  );
    logic [SLV_BYTEW_LOG2:0]   nbytes;
    logic [SLV_BYTEW_LOG2-1:0] base;
    logic [2*SLV_BYTEW-1:0]    m;
    if (size > AXI_SW'(SLV_BYTEW_LOG2)) begin
      nbytes = (SLV_BYTEW_LOG2+1)'(SLV_BYTEW);
    end else begin
      nbytes = (SLV_BYTEW_LOG2+1)'(1) << size;
    end
    base = off & ~SLV_BYTEW_LOG2'(nbytes - (SLV_BYTEW_LOG2+1)'(1));
    m    = ((2*SLV_BYTEW)'(1) << nbytes) - (2*SLV_BYTEW)'(1);
    m    = m << base;
    m    = m & ~(((2*SLV_BYTEW)'(1) << off) - (2*SLV_BYTEW)'(1));
    return m[SLV_BYTEW-1:0];
  endfunction

  // Expand a per-byte lane mask into a per-bit data mask
  function automatic logic [AXI_DW-1:0] lane_bits(input logic [SLV_BYTEW-1:0] lanes);
    logic [AXI_DW-1:0] b;
    b = '0;
    for (int i = 0; i < SLV_BYTEW; i++) begin
      b[i*8 +: 8] = {8{lanes[i]}};
    end
    return b;
  endfunction

endpackage

// File: rtl/asi_dly_pipe.sv
// Fixed-depth valid/data delay line. Only the valid bits are reset unless
// DATA_RST is set; data stages load only when their input is valid, so the
// last stage holds the most recent beat while the line is idle.
module asi_dly_pipe #(
  parameter int DEPTH    = 1,
  parameter int W        = 8,
  parameter bit DATA_RST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_r;
    logic [W-1:0]     data_r [DEPTH];

    // Shift the valid bits one stage per cycle; reset drops all beats
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= '0;
      end else begin
        valid_r[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) begin
          valid_r[i] <= valid_r[i-1];
        end
      end
    end

    if (DATA_RST) begin : g_drst
      // Advance data only with a valid beat; cleared by reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) data_r[i] <= '0;
        end else begin
          if (in_valid) data_r[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            if (valid_r[i-1]) data_r[i] <= data_r[i-1];
          end
        end
      end
    end else begin : g_dnr
      // Advance data only with a valid beat; no reset needed
      always_ff @(posedge clk) begin
        if (in_valid) data_r[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          if (valid_r[i-1]) data_r[i] <= data_r[i-1];
        end
      end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
  end

endmodule

// File: rtl/asi_rmem.sv
// User-side read stage of the AXI slave: turns per-beat read strobes into
// SRAM reads with range/size checking, byte-lane masking and a one-word
// hold register, returning each beat exactly SLV_WS cycles after m_re.
module asi_rmem
  import asi_pkg::*;
#(
  parameter int               SLV_WS    = 2,
  parameter int               MEM_LAT   = 1,
  parameter int               MEM_AW    = 12,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter bit               LANE_MASK = 1'b1
) (
  input  logic              usr_clk,
  input  logic              usr_reset,
  input  logic              m_re,
  input  logic [AXI_AW-1:0] m_raddr,
  input  logic [AXI_SW-1:0] m_rsize,
  input  logic              m_rlast,
  output logic [AXI_DW-1:0] m_rdata,
  output logic              m_rvalid,
  output logic              m_rslverr,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [AXI_DW-1:0] mem_q,
  input  logic              inv
);

  localparam int WORD_W = AXI_AW - SLV_BYTEW_LOG2;

  logic [AXI_AW:0]     off;
  logic [WORD_W-1:0]   word;
  logic                range_err;
  logic                size_err;
  logic                err;
  logic                hit;
  rmem_beat_t          issue_beat;
  logic                tag_valid;
  logic [MEM_AW-1:0]   tag_word;
  logic                ret_valid;
  rmem_beat_t          ret_beat;
  logic [AXI_DW-1:0]   hold_q;
  logic [AXI_DW-1:0]   raw;
  logic [AXI_DW-1:0]   shaped;
  logic [AXI_DW:0]     out_in;
  logic [AXI_DW:0]     out_q;

  // Issue stage: locate the word, flag bad beats, decide hit vs SRAM read
  always_comb begin
    off       = {1'b0, m_raddr} - {1'b0, BASE_ADDR};
    word      = off[AXI_AW-1:SLV_BYTEW_LOG2];
    range_err = off[AXI_AW] | ((word >> MEM_AW) != '0);
    size_err  = m_rsize > AXI_SW'(SLV_BYTEW_LOG2);
    err       = range_err | size_err;
    // A coincident invalidate forces a miss so the beat sees fresh data
    hit       = tag_valid & ~inv & ~err & (word[MEM_AW-1:0] == tag_word);
    mem_re    = m_re & ~err & ~hit & ~usr_reset;
    if (mem_re) begin
      mem_addr = word[MEM_AW-1:0];
    end else begin
      mem_addr = '0;
    end
    issue_beat.err   = err;
    issue_beat.hit   = hit;
    issue_beat.lanes = lane_mask(m_rsize, off[SLV_BYTEW_LOG2-1:0]);
    issue_beat.last  = m_rlast;
  end

  // Hold-register tag: track the last good word read; invalidate wins
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      tag_valid <= 1'b0;
      tag_word  <= '0;
    end else if (inv) begin
      tag_valid <= 1'b0;
    end else if (m_re && !err) begin
      tag_valid <= 1'b1;
      tag_word  <= word[MEM_AW-1:0];
    end
  end

  asi_dly_pipe #(
    .DEPTH    (MEM_LAT),
    .W        ($bits(rmem_beat_t)),
    .DATA_RST (1'b0)
  ) u_ret_pipe (
    .clk       (usr_clk),
    .rst       (usr_reset),
    .in_valid  (m_re),
    .in_data   (issue_beat),
    .out_valid (ret_valid),
    .out_data  (ret_beat)
  );

  // Return stage: choose hold vs SRAM data, then mask lanes / zero errors
  always_comb begin
    if (ret_beat.hit) begin
      raw = hold_q;
    end else begin
      raw = mem_q;
    end
    if (ret_beat.err) begin
      shaped = '0;
    end else if (LANE_MASK) begin
      shaped = raw & lane_bits(ret_beat.lanes);
    end else begin
      shaped = raw;
    end
    out_in = {ret_beat.err, shaped};
  end

  // Capture each fresh SRAM word so later same-word beats can reuse it
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      hold_q <= '0;
    end else if (ret_valid && !ret_beat.err && !ret_beat.hit) begin
      hold_q <= mem_q;
    end
  end

  asi_dly_pipe #(
    .DEPTH    (SLV_WS - MEM_LAT),
    .W        (AXI_DW + 1),
    .DATA_RST (1'b1)
  ) u_out_pipe (
    .clk       (usr_clk),
    .rst       (usr_reset),
    .in_valid  (ret_valid),
    .in_data   (out_in),
    .out_valid (m_rvalid),
    .out_data  (out_q)
  );

  assign m_rdata   = out_q[AXI_DW-1:0];
  assign m_rslverr = m_rvalid & out_q[AXI_DW];

endmodule
